// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-configuration slice.
// Holds the register map addresses and the bit positions of the fields
// inside one SPI frame. The frame layout, MSB first, is:
//   [15]   R/W flag (1 = write)
//   [14:8] register address
//   [7:0]  register data
package spi_reg_pkg;

  // Register map seen by the PWM peripheral
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // Frame field positions
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

endpackage

// File: rtl/sync_edge.sv
// Pad synchronizer with edge detection.
// Brings an asynchronous pad signal into the clk domain through a chain of
// SYNC_STAGES flops (must be at least 2), then compares the synchronized
// level against one extra history flop to produce single-cycle rise and
// fall pulses.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; all flops load RESET_VAL
//   async_i  in   raw pad signal, asynchronous to clk
//   level_o  out  synchronized level
//   rise_o   out  one-cycle pulse on a synchronized 0->1 transition
//   fall_o   out  one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain plus history flop. Resetting to RESET_VAL lets an
  // idle-high line (chip select) come out of reset without a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge pulses compare the newest synchronized level with its history
  always_comb begin
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

endmodule

// File: rtl/spi_reg_config.sv
// SPI write-only configuration port for the PWM peripheral.
// Receives 16-bit mode-0 frames (MSB first) and, when a complete, valid
// write frame ends, loads the addressed configuration register. Frames
// that are short, long, reads, or aimed at an unmapped address are
// dropped without side effects. There is no read-back path.
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   sclk             in   SPI clock from pad (asynchronous)
//   copi             in   SPI data from pad, MSB first
//   ncs              in   SPI chip select from pad, active low
//   en_reg_out_7_0   out  reg 0x00, output enables 7:0
//   en_reg_out_15_8  out  reg 0x01, output enables 15:8
//   en_reg_pwm_7_0   out  reg 0x02, PWM mode select 7:0
//   en_reg_pwm_15_8  out  reg 0x03, PWM mode select 15:8
//   pwm_duty_cycle   out  reg 0x04, shared duty cycle
//   wr_strobe        out  one-cycle pulse in the cycle a register changes
module spi_reg_config
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  FrameCnt = CNT_W'(FRAME_BITS);
  localparam logic [6:0]        MaxAddr  = 7'(MAX_ADDR);

  // Synchronized pad signals
  logic sclkLevel, sclkRise, sclkFall;
  logic ncsLevel, ncsRise, ncsFall;
  logic copiLevel, copiRise, copiFall;
  logic unusedSignals;

  // Frame receive state
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic                  overflow_q, overflow_d;

  // Commit pipeline
  logic       commitNow;
  logic       commit_q;
  logic [6:0] commitAddr_q;
  logic [7:0] commitData_q;

  // Register bank
  logic [7:0] enOutLo_q, enOutLo_d;
  logic [7:0] enOutHi_q, enOutHi_d;
  logic [7:0] enPwmLo_q, enPwmLo_d;
  logic [7:0] enPwmHi_q, enPwmHi_d;
  logic [7:0] duty_q, duty_d;
  logic       wrStrobe_q;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (sclk),
    .level_o (sclkLevel),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  // Chip select idles high, so its synchronizer resets to 1
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncNcs (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ncs),
    .level_o (ncsLevel),
    .rise_o  (ncsRise),
    .fall_o  (ncsFall)
  );

  // Only the level of copi matters; its edge outputs go unused
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncCopi (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (copi),
    .level_o (copiLevel),
    .rise_o  (copiRise),
    .fall_o  (copiFall)
  );

  assign unusedSignals = ^{sclkLevel, sclkFall, copiRise, copiFall};

  // Frame receive next state. A chip-select fall starts a fresh frame.
  // An sclk rise shifts only while selected, and never in the cycle that
  // chip select rises, so a late edge cannot disturb the frame being
  // judged for commit. The counter saturates at a full frame; any edge
  // beyond that marks the frame as too long.
  always_comb begin
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    overflow_d = overflow_q;
    if (ncsFall) begin
      bitCnt_d   = '0;
      overflow_d = 1'b0;
    end
    if (sclkRise && !ncsLevel && !ncsRise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copiLevel};
      if (bitCnt_d == FrameCnt) begin
        overflow_d = 1'b1;
      end else begin
        bitCnt_d = bitCnt_d + 1'b1;
      end
    end
  end

  // Frame receive state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bitCnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Commit decision at the end of a frame: exactly a full frame, no extra
  // edges, write flag set and a mapped address.
  always_comb begin
    commitNow = ncsRise
             && (bitCnt_q == FrameCnt)
             && !overflow_q
             && shift_q[RW_BIT]
             && (shift_q[ADDR_MSB:ADDR_LSB] <= MaxAddr);
  end

  // Capture the accepted address/data so the register bank can apply it
  // on the following edge, independent of any new frame starting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q     <= 1'b0;
      commitAddr_q <= '0;
      commitData_q <= '0;
    end else begin
      commit_q <= commitNow;
      if (commitNow) begin
        commitAddr_q <= shift_q[ADDR_MSB:ADDR_LSB];
        commitData_q <= shift_q[DATA_MSB:0];
      end
    end
  end

  // Register bank write decode
  always_comb begin
    enOutLo_d = enOutLo_q;
    enOutHi_d = enOutHi_q;
    enPwmLo_d = enPwmLo_q;
    enPwmHi_d = enPwmHi_q;
    duty_d    = duty_q;
    if (commit_q) begin
      case (commitAddr_q)
        ADDR_EN_OUT_LO: enOutLo_d = commitData_q;
        ADDR_EN_OUT_HI: enOutHi_d = commitData_q;
        ADDR_EN_PWM_LO: enPwmLo_d = commitData_q;
        ADDR_EN_PWM_HI: enPwmHi_d = commitData_q;
        ADDR_DUTY:      duty_d    = commitData_q;
        default: ;
      endcase
    end
  end

  // Register bank and write strobe; the strobe is high in the same cycle
  // the new value appears on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enOutLo_q  <= '0;
      enOutHi_q  <= '0;
      enPwmLo_q  <= '0;
      enPwmHi_q  <= '0;
      duty_q     <= '0;
      wrStrobe_q <= 1'b0;
    end else begin
      enOutLo_q  <= enOutLo_d;
      enOutHi_q  <= enOutHi_d;
      enPwmLo_q  <= enPwmLo_d;
      enPwmHi_q  <= enPwmHi_d;
      duty_q     <= duty_d;
      wrStrobe_q <= commit_q;
    end
  end

  assign en_reg_out_7_0  = enOutLo_q;
  assign en_reg_out_15_8 = enOutHi_q;
  assign en_reg_pwm_7_0  = enPwmLo_q;
  assign en_reg_pwm_15_8 = enPwmHi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_strobe       = wrStrobe_q;

endmodule
